// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared widths, FSM state type and helpers for acc_stream_32
//
// Purpose : common definitions for the packet accumulator and its adder.
// Contents: DATA_W (operand/sum width), CNT_W (beat counter width),
//           state_e (IDLE / ACC / OUT) and the packet-closing predicate.

package acc_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,   // no partial sum held
    ACC  = 2'd1,   // partial sum held, waiting for more beats
    OUT  = 2'd2    // result presented on the m_* side
  } state_e;

  // A beat closes its packet on s_last or when the post-increment count
  // reaches the configured beat limit.
  function automatic logic is_closing(input logic             last,
                                      input logic [CNT_W-1:0] cnt_next,
                                      input logic [CNT_W-1:0] max_cnt);
    return last | (cnt_next == max_cnt);
  endfunction

endpackage

// File: rtl/brent_kung_adder_32bit.sv
// rtl/brent_kung_adder_32bit.sv - 32-bit Brent-Kung parallel-prefix adder
//
// Purpose : sum = in_op1 + in_op2 + cin, 32-bit result plus carry-out.
// Ports   : in_op1 [31:0] in  first operand
//           in_op2 [31:0] in  second operand
//           cin          in  carry-in
//           sum   [31:0] out sum modulo 2^32
//           cout         out carry-out of bit 31

module brent_kung_adder_32bit
  import acc_pkg::*;
(
  input  logic [DATA_W-1:0] in_op1,
  input  logic [DATA_W-1:0] in_op2,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic [DATA_W-1:0] p_bit;  // per-bit propagate, kept for the final XOR
  logic [DATA_W-1:0] gg;     // group generate, becomes prefix carry per bit
  logic [DATA_W-1:0] pp;     // group propagate

  always_comb begin
    p_bit = in_op1 ^ in_op2;
    gg    = in_op1 & in_op2;
    pp    = p_bit;
    // Fold carry-in into bit 0 so the tree yields carries straight out.
    gg[0] = gg[0] | (pp[0] & cin);

    // Up-sweep: build power-of-two spans at positions 2^(l+1)-1 + k*2^(l+1).
    for (int l = 0; l < 5; l++) begin
      for (int i = (2 << l) - 1; i < DATA_W; i += (2 << l)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        pp[i] = pp[i] & pp[i - (1 << l)];
      end
    end

    // Down-sweep: fill in the remaining positions from the nearest span end.
    for (int l = 3; l >= 0; l--) begin
      for (int i = (3 << l) - 1; i < DATA_W; i += (2 << l)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        pp[i] = pp[i] & pp[i - (1 << l)];
      end
    end

    // gg[i] now holds the carry out of bit i.
    sum[0] = p_bit[0] ^ cin;
    for (int i = 1; i < DATA_W; i++) begin
      sum[i] = p_bit[i] ^ gg[i - 1];
    end
    cout = gg[DATA_W-1];
  end

endmodule

// File: rtl/acc_stream_32.sv
// rtl/acc_stream_32.sv - streaming packet accumulator with overflow and beat limit
//
// Purpose : sums the 32-bit beats of each packet and presents one result
//           per packet; packets longer than MAX_BEATS are force-closed.
// Params  : MAX_BEATS  maximum beats per packet (1..65535)
// Ports   : clk            in  clock, rising edge
//           rst_n          in  asynchronous active-low reset
//           s_valid/s_ready    beat handshake (s_ready low in OUT and reset)
//           s_data  [31:0] in  operand beat
//           s_last         in  final beat of the packet
//           m_valid/m_ready    result handshake
//           m_sum   [31:0] out packet sum modulo 2^32
//           m_ovf          out at least one carry-out during the packet
//           m_cnt   [15:0] out beats accumulated
//           m_trunc        out packet closed on MAX_BEATS without s_last

module acc_stream_32 #(
  parameter int MAX_BEATS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_sum,
  output logic        m_ovf,
  output logic [15:0] m_cnt,
  output logic        m_trunc
);

  import acc_pkg::*;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              rdy_en_q, rdy_en_d;
  logic [DATA_W-1:0] m_sum_q, m_sum_d;
  logic              m_ovf_q, m_ovf_d;
  logic [CNT_W-1:0]  m_cnt_q, m_cnt_d;
  logic              m_trunc_q, m_trunc_d;

  logic [DATA_W-1:0] add_sum;
  logic              add_cout;
  logic [CNT_W-1:0]  cnt_inc;
  logic              ovf_base;
  logic              beat_ok;
  logic              closing;

  // acc_q and cnt_q are cleared whenever a packet closes, so in IDLE the
  // adder sees 0 + s_data and the shared path also loads the first beat.
  brent_kung_adder_32bit u_adder (
    .in_op1 (acc_q),
    .in_op2 (s_data),
    .cin    (1'b0),
    .sum    (add_sum),
    .cout   (add_cout)
  );

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign ovf_base = (state_q == ACC) ? ovf_q : 1'b0;
  assign closing  = is_closing(s_last, cnt_inc, MAX_CNT);

  // rdy_en_q holds s_ready low through reset and until the first edge after it.
  assign s_ready = rdy_en_q & (state_q != OUT);
  assign beat_ok = s_valid & s_ready;

  assign m_valid = (state_q == OUT);
  assign m_sum   = m_sum_q;
  assign m_ovf   = m_ovf_q;
  assign m_cnt   = m_cnt_q;
  assign m_trunc = m_trunc_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    rdy_en_d  = 1'b1;
    m_sum_d   = m_sum_q;
    m_ovf_d   = m_ovf_q;
    m_cnt_d   = m_cnt_q;
    m_trunc_d = m_trunc_q;

    case (state_q)
      IDLE, ACC: begin
        if (beat_ok) begin
          if (closing) begin
            state_d   = OUT;
            m_sum_d   = add_sum;
            m_ovf_d   = ovf_base | add_cout;
            m_cnt_d   = cnt_inc;
            m_trunc_d = ~s_last;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
          end else begin
            state_d = ACC;
            acc_d   = add_sum;
            cnt_d   = cnt_inc;
            ovf_d   = ovf_base | add_cout;
          end
        end
      end
      OUT: begin
        if (m_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      rdy_en_q  <= 1'b0;
      m_sum_q   <= '0;
      m_ovf_q   <= 1'b0;
      m_cnt_q   <= '0;
      m_trunc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      rdy_en_q  <= rdy_en_d;
      m_sum_q   <= m_sum_d;
      m_ovf_q   <= m_ovf_d;
      m_cnt_q   <= m_cnt_d;
      m_trunc_q <= m_trunc_d;
    end
  end

endmodule
